// File: rtl/box_overlay.sv
// Draws up to N_BOX rectangular outlines onto an RGB565 stream with 2-cycle latency; boxes update only at vsync.
// Optional build macro BOX_FILL_EN blends box interiors 50/50 with the box colour.
`timescale 1ns/1ps
module box_overlay #(
  parameter int N_BOX       = 4,
  parameter int H_BOX_WIDTH = 2,
  parameter int V_BOX_WIDTH = 2,
  parameter int PIX_W       = 16,
  parameter int COORD_W     = 11,
  localparam int IW         = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vsync,
  input  logic               in_hsync,
  input  logic               in_de,
  input  logic [PIX_W-1:0]   in_pix,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IW-1:0]      cfg_idx,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_x1,
  input  logic [COORD_W-1:0] cfg_y0,
  input  logic [COORD_W-1:0] cfg_y1,
  input  logic [PIX_W-1:0]   cfg_color,
  output logic               out_vsync,
  output logic               out_hsync,
  output logic               out_de,
  output logic [PIX_W-1:0]   out_pix,
  output logic               hit
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] C_MAX = '1;
  localparam logic [CW1-1:0] HW = CW1'(H_BOX_WIDTH);
  localparam logic [CW1-1:0] VW = CW1'(V_BOX_WIDTH);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [PIX_W-1:0]   color;
  } box_t;

  function automatic logic box_inside(input box_t b, input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py);
    return b.en && (b.x0 <= px) && (px <= b.x1) && (b.y0 <= py) && (py <= b.y1);
  endfunction

  // One extra bit on every sum so x1 near the top of the range cannot wrap.
  function automatic logic box_border(input box_t b, input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py);
    logic [CW1-1:0] xw;
    logic [CW1-1:0] yw;
    xw = {1'b0, px};
    yw = {1'b0, py};
    return box_inside(b, px, py) &&
           ((xw < {1'b0, b.x0} + HW) || (xw + HW > {1'b0, b.x1}) ||
            (yw < {1'b0, b.y0} + VW) || (yw + VW > {1'b0, b.y1}));
  endfunction

`ifdef BOX_FILL_EN
  function automatic logic [15:0] blend565(input logic [15:0] a, input logic [15:0] c);
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] b;
    r = {1'b0, a[15:11]} + {1'b0, c[15:11]};
    g = {1'b0, a[10:5]}  + {1'b0, c[10:5]};
    b = {1'b0, a[4:0]}   + {1'b0, c[4:0]};
    return {r[5:1], g[6:1], b[5:1]};
  endfunction
`endif

  logic [COORD_W-1:0] x, y;
  logic               de_prev, vs_prev;
  logic               vs_rise, de_fall, wr;
  box_t               pend [N_BOX];
  box_t               act  [N_BOX];

  assign vs_rise   = in_vsync & ~vs_prev;
  assign de_fall   = ~in_de & de_prev;
  assign cfg_ready = ~vs_rise;
  assign wr        = cfg_valid & cfg_ready & (int'(cfg_idx) < N_BOX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      de_prev <= in_de;
      vs_prev <= in_vsync;
      if (in_de) begin
        if (x != C_MAX) x <= x + 1'b1;
      end else begin
        x <= '0;
      end
      if (vs_rise)                    y <= '0;
      else if (de_fall && y != C_MAX) y <= y + 1'b1;
    end
  end

  // Commit wins over a write in the vsync-rise cycle; cfg_ready holds that write off for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BOX; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      if (vs_rise) act <= pend;
      if (wr) pend[cfg_idx] <= {cfg_en, cfg_x0, cfg_y0, cfg_x1, cfg_y1, cfg_color};
    end
  end

  logic [N_BOX-1:0] border_c;
`ifdef BOX_FILL_EN
  logic [N_BOX-1:0] inside_c;
`endif

  always_comb begin
    border_c = '0;
`ifdef BOX_FILL_EN
    inside_c = '0;
`endif
    for (int i = 0; i < N_BOX; i++) begin
      border_c[i] = box_border(act[i], x, y);
`ifdef BOX_FILL_EN
      inside_c[i] = box_inside(act[i], x, y);
`endif
    end
  end

  // Stage 1: per-box flags and the delayed stream
  logic               vld_p1, vs_p1, hs_p1;
  logic [PIX_W-1:0]   pix_p1;
  logic [N_BOX-1:0]   border_p1;
`ifdef BOX_FILL_EN
  logic [N_BOX-1:0]   fill_p1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vs_p1     <= 1'b0;
      hs_p1     <= 1'b0;
      pix_p1    <= '0;
      border_p1 <= '0;
`ifdef BOX_FILL_EN
      fill_p1   <= '0;
`endif
    end else begin
      vld_p1    <= in_de;
      vs_p1     <= in_vsync;
      hs_p1     <= in_hsync;
      pix_p1    <= in_pix;
      border_p1 <= border_c;
`ifdef BOX_FILL_EN
      fill_p1   <= inside_c & ~border_c;
`endif
    end
  end

  // Stage 2: priority mux, lowest index wins; any border beats any fill
  logic [PIX_W-1:0] sel_pix;
  logic             sel_hit;

  always_comb begin
    sel_pix = pix_p1;
    sel_hit = 1'b0;
`ifdef BOX_FILL_EN
    for (int i = N_BOX - 1; i >= 0; i--) begin
      if (fill_p1[i]) begin
        sel_pix = blend565(pix_p1, act[i].color);
        sel_hit = 1'b1;
      end
    end
`endif
    for (int i = N_BOX - 1; i >= 0; i--) begin
      if (border_p1[i]) begin
        sel_pix = act[i].color;
        sel_hit = 1'b1;
      end
    end
    if (!vld_p1) begin
      sel_pix = '0;
      sel_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_de    <= 1'b0;
      out_pix   <= '0;
      hit       <= 1'b0;
    end else begin
      out_vsync <= vs_p1;
      out_hsync <= hs_p1;
      out_de    <= vld_p1;
      out_pix   <= sel_pix;
      hit       <= sel_hit;
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Randomized bench for box_overlay: frames are generated with known (x,y) and compared to a rectangle model.
`timescale 1ns/1ps
module tb_box_overlay;
  localparam int N  = 4;
  localparam int HB = 2;
  localparam int VB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vsync, in_hsync, in_de;
  logic [15:0] in_pix;
  logic        cfg_valid, cfg_ready, cfg_en;
  logic [1:0]  cfg_idx;
  logic [10:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  logic [15:0] cfg_color;
  logic        out_vsync, out_hsync, out_de, hit;
  logic [15:0] out_pix;

  always #5 clk = ~clk;

  box_overlay #(.N_BOX(N), .H_BOX_WIDTH(HB), .V_BOX_WIDTH(VB), .PIX_W(16), .COORD_W(11)) dut (
    .clk(clk), .rst(rst),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de), .in_pix(in_pix),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1), .cfg_color(cfg_color),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de), .out_pix(out_pix), .hit(hit)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending/active box lists and the current raster position.
  bit          p_en [N], a_en [N];
  int          p_x0 [N], p_y0 [N], p_x1 [N], p_y1 [N];
  int          a_x0 [N], a_y0 [N], a_x1 [N], a_y1 [N];
  logic [15:0] p_col [N], a_col [N];
  bit          prev_vs;
  int          cur_x, cur_y;
  logic [19:0] exp_q [$];

  function automatic bit on_box(int i, int px, int py);
    return a_en[i] && px >= a_x0[i] && px <= a_x1[i] && py >= a_y0[i] && py <= a_y1[i];
  endfunction

  function automatic bit on_edge(int i, int px, int py);
    return on_box(i, px, py) && (px < a_x0[i] + HB || px + HB > a_x1[i] ||
                                 py < a_y0[i] + VB || py + VB > a_y1[i]);
  endfunction

  function automatic logic [15:0] mix(logic [15:0] p, logic [15:0] c);
    int r, g, b;
    r = ((int'(p) >> 11) + (int'(c) >> 11)) / 2;
    g = (((int'(p) >> 5) & 63) + ((int'(c) >> 5) & 63)) / 2;
    b = ((int'(p) & 31) + (int'(c) & 31)) / 2;
    return 16'((r << 11) | (g << 5) | b);
  endfunction

  function automatic logic [16:0] model_pix(int px, int py, logic [15:0] pix);
    for (int i = 0; i < N; i++)
      if (on_edge(i, px, py)) return {1'b1, a_col[i]};
`ifdef BOX_FILL_EN
    for (int i = 0; i < N; i++)
      if (on_box(i, px, py)) return {1'b1, mix(pix, a_col[i])};
`endif
    return {1'b0, pix};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      p_en[i] = 1'b0;
      a_en[i] = 1'b0;
    end
    prev_vs = 1'b0;
    exp_q.delete();
  endtask

  // One pixel clock: drive, check ready, predict, clock, compare the output from the previous cycle.
  task automatic step(input bit vs, input bit hs, input bit de, input logic [15:0] pix);
    bit          rise, acc;
    logic [16:0] m;
    in_vsync = vs; in_hsync = hs; in_de = de; in_pix = pix;
    #1;
    rise = vs && !prev_vs;
    check("cfg_ready", cfg_ready, !rise);
    m = de ? model_pix(cur_x, cur_y, pix) : 17'd0;
    exp_q.push_back({vs, hs, de, m});
    acc = cfg_valid && !rise;
    if (rise) begin
      for (int i = 0; i < N; i++) begin
        a_en[i] = p_en[i]; a_x0[i] = p_x0[i]; a_y0[i] = p_y0[i];
        a_x1[i] = p_x1[i]; a_y1[i] = p_y1[i]; a_col[i] = p_col[i];
      end
    end else if (acc && int'(cfg_idx) < N) begin
      p_en[cfg_idx] = cfg_en; p_x0[cfg_idx] = int'(cfg_x0); p_y0[cfg_idx] = int'(cfg_y0);
      p_x1[cfg_idx] = int'(cfg_x1); p_y1[cfg_idx] = int'(cfg_y1); p_col[cfg_idx] = cfg_color;
    end
    prev_vs = vs;
    @(posedge clk);
    #1;
    if (acc) cfg_valid = 1'b0;
    if (exp_q.size() >= 2)
      check("stream", {out_vsync, out_hsync, out_de, hit, out_pix}, exp_q.pop_front());
  endtask

  task automatic cfg_set(input int idx, input bit en, input int x0, input int y0,
                         input int x1, input int y1, input logic [15:0] col);
    cfg_idx = 2'(idx); cfg_en = en;
    cfg_x0 = 11'(x0); cfg_y0 = 11'(y0); cfg_x1 = 11'(x1); cfg_y1 = 11'(y1);
    cfg_color = col;
    cfg_valid = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input bit en, input int x0, input int y0,
                           input int x1, input int y1, input logic [15:0] col);
    cfg_set(idx, en, x0, y0, x1, y1, col);
    for (int k = 0; k < 8 && cfg_valid; k++) step(1'b0, 1'b0, 1'b0, 16'h0);
    check("cfg_accept", cfg_valid, 1'b0);
    cfg_valid = 1'b0;
  endtask

  task automatic frame_head();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic frame(input int w, input int h, input bit solid);
    frame_head();
    for (int ly = 0; ly < h; ly++) begin
      for (int lx = 0; lx < w; lx++) begin
        cur_x = lx;
        cur_y = ly;
        step(1'b0, 1'b0, 1'b1, solid ? 16'hFFFF : 16'($urandom));
      end
      step(1'b0, 1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_pix = 16'h0;
    cfg_valid = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0;
    cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0; cfg_color = 16'h0;
    cur_x = 0; cur_y = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {out_vsync, out_hsync, out_de, hit, out_pix}, 20'h0);
    check("reset_rdy", cfg_ready, 1'b1);
    rst = 1'b0;

    frame(16, 4, 1'b0);

    cfg_write(0, 1'b1, 100, 50, 199, 99, 16'hF800);
    frame(205, 62, 1'b0);

    cfg_write(0, 1'b1, 10, 5, 40, 20, 16'hF800);
    cfg_write(1, 1'b1, 30, 10, 60, 30, 16'h07E0);
    frame(64, 32, 1'b0);

    // write presented exactly on the vsync rise: stalled one cycle, visible a frame later
    cfg_set(2, 1'b1, 5, 2, 25, 12, 16'h001F);
    frame(64, 32, 1'b0);
    check("rise_wr_landed", cfg_valid, 1'b0);
    frame(64, 32, 1'b0);

    cfg_write(0, 1'b1, 40, 2, 20, 10, 16'hF800);
    cfg_write(1, 1'b1, 2, 20, 10, 8, 16'h07E0);
    cfg_write(2, 1'b0, 0, 0, 63, 31, 16'h001F);
    cfg_write(3, 1'b1, 1200, 1, 2047, 5, 16'hFFE0);
    frame(1280, 4, 1'b0);

    cfg_write(3, 1'b0, 0, 0, 0, 0, 16'h0);
    cfg_write(0, 1'b1, 4, 2, 30, 12, 16'h0000);
    frame(40, 16, 1'b1);

    repeat (6) begin
      for (int i = 0; i < N; i++)
        cfg_write(i, $urandom_range(0, 3) != 0, $urandom_range(0, 60), $urandom_range(0, 22),
                  $urandom_range(0, 63), $urandom_range(0, 23), 16'($urandom));
      frame(64, 24, 1'b0);
    end

    // reset in the middle of a drawn line
    cfg_write(0, 1'b1, 0, 0, 20, 5, 16'hF800);
    frame(24, 2, 1'b0);
    frame_head();
    for (int lx = 0; lx < 10; lx++) begin
      cur_x = lx;
      cur_y = 0;
      step(1'b0, 1'b0, 1'b1, 16'($urandom));
    end
    check("pre_reset_hit", hit, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_out", {out_vsync, out_hsync, out_de, hit, out_pix}, 20'h0);
    check("rst_async_rdy", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
    check("rst_next_out", {out_vsync, out_hsync, out_de, hit, out_pix}, 20'h0);
    check("rst_next_rdy", cfg_ready, 1'b1);
    rst = 1'b0;
    model_reset();
    frame(32, 8, 1'b0);
    frame(32, 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
